// File: rtl/sys_timer_periph.sv
// Memory-mapped 32-bit down-counting timer with prescaler, auto-reload/one-shot modes,
// compare toggle pin and level interrupt. Combinational reads, edge-applied writes.
module sys_timer_periph #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] sys_w_addr,
  input  logic [31:0] sys_w_line,
  input  logic        sys_write,
  input  logic [31:0] sys_r_addr,
  input  logic        sys_read,
  output logic [31:0] sys_r_line,
  output logic        tmr_out,
  output logic        irq
);

  localparam logic [2:0] IdxCtrl    = 3'd0;
  localparam logic [2:0] IdxPresc   = 3'd1;
  localparam logic [2:0] IdxCount   = 3'd2;
  localparam logic [2:0] IdxReload  = 3'd3;
  localparam logic [2:0] IdxCompare = 3'd4;
  localparam logic [2:0] IdxStatus  = 3'd5;

  logic [4:0]  ctrl_q, ctrl_d;
  logic [15:0] presc_q, presc_d;
  logic [15:0] pcnt_q, pcnt_d;
  logic [31:0] count_q, count_d;
  logic [31:0] reload_q, reload_d;
  logic [31:0] compare_q, compare_d;
  logic [1:0]  status_q, status_d;
  logic        out_q, out_d;

  logic        w_sel, r_sel, tick;
  logic [2:0]  w_idx, r_idx;
  logic [1:0]  set_flags;
  logic        unused_addr_lsbs;

  assign w_sel = sys_write && (sys_w_addr[31:5] == BASE_ADDR[31:5]);
  assign r_sel = sys_read && (sys_r_addr[31:5] == BASE_ADDR[31:5]);
  assign w_idx = sys_w_addr[4:2];
  assign r_idx = sys_r_addr[4:2];
  assign unused_addr_lsbs = ^{sys_w_addr[1:0], sys_r_addr[1:0]};

  assign tick = ctrl_q[0] && (pcnt_q == presc_q);

  always_comb begin
    ctrl_d    = ctrl_q;
    presc_d   = presc_q;
    pcnt_d    = pcnt_q;
    count_d   = count_q;
    reload_d  = reload_q;
    compare_d = compare_q;
    status_d  = status_q;
    out_d     = out_q;
    set_flags = 2'b00;

    if (ctrl_q[0]) pcnt_d = tick ? 16'd0 : pcnt_q + 16'd1;

    if (tick) begin
      if (count_q == compare_q) begin
        set_flags[1] = 1'b1;
        out_d        = ~out_q;
      end
      if (count_q == 32'd0) begin
        count_d      = reload_q;
        set_flags[0] = 1'b1;
        if (ctrl_q[1]) ctrl_d[0] = 1'b0;
      end else begin
        count_d = count_q - 32'd1;
      end
    end

    // Bus writes override the tick's own updates; flag sets still win over W1C below.
    if (w_sel) begin
      case (w_idx)
        IdxCtrl:    ctrl_d    = sys_w_line[4:0];
        IdxPresc: begin
          presc_d = sys_w_line[15:0];
          pcnt_d  = 16'd0;
        end
        IdxCount:   count_d   = sys_w_line;
        IdxReload:  reload_d  = sys_w_line;
        IdxCompare: compare_d = sys_w_line;
        IdxStatus:  status_d  = status_q & ~sys_w_line[1:0];
        default:    ;
      endcase
    end

    status_d = status_d | set_flags;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q    <= '0;
      presc_q   <= '0;
      pcnt_q    <= '0;
      count_q   <= '0;
      reload_q  <= '0;
      compare_q <= '0;
      status_q  <= '0;
      out_q     <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      presc_q   <= presc_d;
      pcnt_q    <= pcnt_d;
      count_q   <= count_d;
      reload_q  <= reload_d;
      compare_q <= compare_d;
      status_q  <= status_d;
      out_q     <= out_d;
    end
  end

  always_comb begin
    sys_r_line = 32'd0;
    if (r_sel) begin
      case (r_idx)
        IdxCtrl:    sys_r_line = {27'd0, ctrl_q};
        IdxPresc:   sys_r_line = {16'd0, presc_q};
        IdxCount:   sys_r_line = count_q;
        IdxReload:  sys_r_line = reload_q;
        IdxCompare: sys_r_line = compare_q;
        IdxStatus:  sys_r_line = {30'd0, status_q};
        default:    sys_r_line = 32'd0;
      endcase
    end
  end

  assign tmr_out = out_q & ctrl_q[2];
  assign irq     = (status_q[0] & ctrl_q[3]) | (status_q[1] & ctrl_q[4]);

endmodule

// File: tb/tb_sys_timer_periph.sv
// Bench for sys_timer_periph: directed scenario tasks plus a randomized run compared
// against a behavioural model of the timer's register set.
module tb_sys_timer_periph;

  localparam logic [31:0] BASE = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] sys_w_addr, sys_w_line, sys_r_addr, sys_r_line;
  logic        sys_write, sys_read, tmr_out, irq;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  logic [4:0]  m_ctrl = '0;
  logic [15:0] m_presc = '0, m_pcnt = '0;
  logic [31:0] m_count = '0, m_reload = '0, m_compare = '0;
  logic [1:0]  m_status = '0;
  logic        m_out = 1'b0;

  always #5 clk = ~clk;

  sys_timer_periph #(.BASE_ADDR(BASE)) dut (
    .clk        (clk),
    .rst        (rst),
    .sys_w_addr (sys_w_addr),
    .sys_w_line (sys_w_line),
    .sys_write  (sys_write),
    .sys_r_addr (sys_r_addr),
    .sys_read   (sys_read),
    .sys_r_line (sys_r_line),
    .tmr_out    (tmr_out),
    .irq        (irq)
  );

  function automatic logic [31:0] m_read(input logic rd, input logic [31:0] addr);
    if (!rd || addr[31:5] != BASE[31:5]) return 32'd0;
    case (addr[4:2])
      3'd0:    return {27'd0, m_ctrl};
      3'd1:    return {16'd0, m_presc};
      3'd2:    return m_count;
      3'd3:    return m_reload;
      3'd4:    return m_compare;
      3'd5:    return {30'd0, m_status};
      default: return 32'd0;
    endcase
  endfunction

  // Advance one clock: the model consumes the current inputs, then the DUT edge occurs.
  task automatic step();
    logic [4:0]  c;
    logic [15:0] p, pc;
    logic [31:0] cnt, rl, cp;
    logic [1:0]  st, setb;
    logic        o, tick;
    c = m_ctrl; p = m_presc; pc = m_pcnt; cnt = m_count; rl = m_reload;
    cp = m_compare; st = m_status; o = m_out; setb = 2'b00;
    if (rst) begin
      c = '0; p = '0; pc = '0; cnt = '0; rl = '0; cp = '0; st = '0; o = 1'b0;
    end else begin
      tick = m_ctrl[0] && (m_pcnt == m_presc);
      if (m_ctrl[0]) pc = tick ? 16'd0 : m_pcnt + 16'd1;
      if (tick) begin
        if (m_count == m_compare) begin setb[1] = 1'b1; o = ~o; end
        if (m_count == 32'd0) begin
          cnt = m_reload; setb[0] = 1'b1;
          if (m_ctrl[1]) c[0] = 1'b0;
        end else cnt = m_count - 32'd1;
      end
      if (sys_write && sys_w_addr[31:5] == BASE[31:5]) begin
        case (sys_w_addr[4:2])
          3'd0: c = sys_w_line[4:0];
          3'd1: begin p = sys_w_line[15:0]; pc = 16'd0; end
          3'd2: cnt = sys_w_line;
          3'd3: rl = sys_w_line;
          3'd4: cp = sys_w_line;
          3'd5: st = st & ~sys_w_line[1:0];
          default: ;
        endcase
      end
      st = st | setb;
    end
    @(posedge clk);
    #1;
    m_ctrl = c; m_presc = p; m_pcnt = pc; m_count = cnt; m_reload = rl;
    m_compare = cp; m_status = st; m_out = o;
  endtask

  task automatic write_reg(input int idx, input logic [31:0] data);
    sys_w_addr = BASE + (32'(idx) << 2);
    sys_w_line = data;
    sys_write  = 1'b1;
    step();
    sys_write  = 1'b0;
    sys_w_addr = '0;
    sys_w_line = '0;
  endtask

  task automatic rd_addr(input logic [31:0] addr, output logic [31:0] v);
    sys_r_addr = addr;
    sys_read   = 1'b1;
    #1;
    v = sys_r_line;
    sys_read   = 1'b0;
    sys_r_addr = '0;
  endtask

  task automatic rd_idx(input int idx, output logic [31:0] v);
    rd_addr(BASE + (32'(idx) << 2), v);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      if (i == 4) step();
      rd_idx(i, v);
      checks++;
      if (v !== 32'd0) begin
        errors++; $display("FAIL reset_reg%0d: got %h expected 0", i, v);
      end
    end
    checks++;
    if (irq !== 1'b0 || tmr_out !== 1'b0) begin
      errors++; $display("FAIL reset_outs: irq=%b tmr_out=%b expected 0 0", irq, tmr_out);
    end
    write_reg(3, 32'hDEAD_BEEF);
    rd_addr(BASE + 32'h20, v);
    checks++;
    if (v !== 32'd0) begin errors++; $display("FAIL decode_oor: got %h expected 0", v); end
    rd_idx(3, v);
    checks++;
    if (v !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL reload_rb: got %h expected deadbeef", v);
    end
    write_reg(1, 32'hFFFF_FFFF);
    rd_idx(1, v);
    checks++;
    if (v !== 32'h0000_FFFF) begin
      errors++; $display("FAIL presc_rb: got %h expected 0000ffff", v);
    end
    sys_w_addr = BASE + 32'h2C;  // outside the block, aliases RELOAD's low bits
    sys_w_line = 32'h1234;
    sys_write  = 1'b1;
    step();
    sys_write  = 1'b0;
    write_reg(6, 32'hFFFF_FFFF);
    rd_idx(3, v);
    checks++;
    if (v !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL decode_wr_ignored: got %h expected deadbeef", v);
    end
    rd_idx(6, v);
    checks++;
    if (v !== 32'd0) begin errors++; $display("FAIL idx6_rd: got %h expected 0", v); end
  endtask

  task automatic test_count_reload();
    logic [31:0] v;
    logic [31:0] exp_cnt [3] = '{32'd2, 32'd1, 32'd0};
    do_reset();
    write_reg(2, 32'd3);
    write_reg(3, 32'd5);
    write_reg(1, 32'd0);
    write_reg(0, 32'h09);
    for (int i = 0; i < 3; i++) begin
      step();
      rd_idx(2, v);
      checks++;
      if (v !== exp_cnt[i]) begin
        errors++; $display("FAIL count_k%0d: got %0d expected %0d", i + 1, v, exp_cnt[i]);
      end
    end
    step();
    rd_idx(2, v);
    checks++;
    if (v !== 32'd5) begin errors++; $display("FAIL count_reload: got %0d expected 5", v); end
    rd_idx(5, v);
    checks++;
    if (v[0] !== 1'b1 || irq !== 1'b1) begin
      errors++; $display("FAIL ovf_irq: ovf=%b irq=%b expected 1 1", v[0], irq);
    end
    write_reg(5, 32'h1);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL w1c_irq: got %b expected 0", irq); end
  endtask

  task automatic test_prescaler();
    logic [31:0] v;
    do_reset();
    write_reg(1, 32'd2);
    write_reg(2, 32'd10);
    write_reg(0, 32'h01);
    step(); step();
    rd_idx(2, v);
    checks++;
    if (v !== 32'd10) begin errors++; $display("FAIL presc_e2: got %0d expected 10", v); end
    step();
    rd_idx(2, v);
    checks++;
    if (v !== 32'd9) begin errors++; $display("FAIL presc_e3: got %0d expected 9", v); end
    step(); step();
    rd_idx(2, v);
    checks++;
    if (v !== 32'd9) begin errors++; $display("FAIL presc_e5: got %0d expected 9", v); end
    step();
    rd_idx(2, v);
    checks++;
    if (v !== 32'd8) begin errors++; $display("FAIL presc_e6: got %0d expected 8", v); end
    step();
    write_reg(1, 32'd2);
    step(); step();
    rd_idx(2, v);
    checks++;
    if (v !== 32'd8) begin errors++; $display("FAIL presc_restart_e10: got %0d expected 8", v); end
    step();
    rd_idx(2, v);
    checks++;
    if (v !== 32'd7) begin errors++; $display("FAIL presc_restart_e11: got %0d expected 7", v); end
  endtask

  task automatic test_compare_pin();
    logic [31:0] v;
    do_reset();
    write_reg(4, 32'd2);
    write_reg(2, 32'd4);
    write_reg(3, 32'd4);
    write_reg(0, 32'h15);
    step(); step();
    rd_idx(5, v);
    checks++;
    if (tmr_out !== 1'b0 || v[1] !== 1'b0) begin
      errors++; $display("FAIL cmp_before: pin=%b cmp=%b expected 0 0", tmr_out, v[1]);
    end
    step();
    rd_idx(5, v);
    checks++;
    if (tmr_out !== 1'b1 || v[1] !== 1'b1 || irq !== 1'b1) begin
      errors++;
      $display("FAIL cmp_hit: pin=%b cmp=%b irq=%b expected 1 1 1", tmr_out, v[1], irq);
    end
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (tmr_out !== 1'b1) begin errors++; $display("FAIL pin_hold: got %b expected 1", tmr_out); end
    step();
    checks++;
    if (tmr_out !== 1'b0) begin errors++; $display("FAIL pin_back: got %b expected 0", tmr_out); end
  endtask

  task automatic test_oneshot();
    logic [31:0] v;
    do_reset();
    write_reg(2, 32'd1);
    write_reg(3, 32'd7);
    write_reg(0, 32'h03);
    step(); step();
    rd_idx(2, v);
    checks++;
    if (v !== 32'd7) begin errors++; $display("FAIL oneshot_cnt: got %0d expected 7", v); end
    rd_idx(5, v);
    checks++;
    if (v[0] !== 1'b1) begin errors++; $display("FAIL oneshot_ovf: got %b expected 1", v[0]); end
    rd_idx(0, v);
    checks++;
    if (v !== 32'h02) begin errors++; $display("FAIL oneshot_ctrl: got %h expected 02", v); end
    for (int i = 0; i < 3; i++) step();
    rd_idx(2, v);
    checks++;
    if (v !== 32'd7) begin errors++; $display("FAIL oneshot_hold: got %0d expected 7", v); end
  endtask

  task automatic test_collisions();
    logic [31:0] v;
    do_reset();
    write_reg(3, 32'd9);
    write_reg(2, 32'd1);
    write_reg(0, 32'h01);
    step();
    write_reg(2, 32'd100);
    rd_idx(2, v);
    checks++;
    if (v !== 32'd100) begin errors++; $display("FAIL wr_vs_reload: got %0d expected 100", v); end
    rd_idx(5, v);
    checks++;
    if (v[0] !== 1'b1) begin errors++; $display("FAIL wr_vs_reload_ovf: got %b expected 1", v[0]); end
    write_reg(2, 32'd0);
    write_reg(5, 32'h1);
    rd_idx(5, v);
    checks++;
    if (v[0] !== 1'b1) begin errors++; $display("FAIL w1c_vs_set: got %b expected 1", v[0]); end
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      rd_idx(i, v);
      checks++;
      if (v !== 32'd0) begin errors++; $display("FAIL rst_mid_reg%0d: got %h expected 0", i, v); end
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_rd;
    int idx;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      sys_write = ($urandom_range(0, 3) == 0);
      idx = $urandom_range(0, 7);
      sys_w_addr = BASE + (32'(idx) << 2) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) sys_w_addr = sys_w_addr + 32'h20;
      case (idx)
        0:       sys_w_line = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 31))
                                                          : 32'($urandom_range(0, 31) | 1);
        5:       sys_w_line = 32'($urandom_range(0, 3));
        default: sys_w_line = ($urandom_range(0, 7) == 0) ? $urandom
                                                          : 32'($urandom_range(0, 6));
      endcase
      sys_read = ($urandom_range(0, 3) != 0);
      sys_r_addr = ($urandom_range(0, 3) == 0) ? sys_w_addr
                                               : BASE + 32'($urandom_range(0, 47));
      #1;
      exp_rd = m_read(sys_read, sys_r_addr);
      checks++;
      if (sys_r_line !== exp_rd) begin
        errors++; $display("FAIL rand_rd[%0d]: got %h expected %h", n, sys_r_line, exp_rd);
      end
      checks++;
      if (irq !== ((m_status[0] & m_ctrl[3]) | (m_status[1] & m_ctrl[4]))) begin
        errors++; $display("FAIL rand_irq[%0d]: got %b expected %b", n, irq,
                           (m_status[0] & m_ctrl[3]) | (m_status[1] & m_ctrl[4]));
      end
      checks++;
      if (tmr_out !== (m_out & m_ctrl[2])) begin
        errors++; $display("FAIL rand_pin[%0d]: got %b expected %b", n, tmr_out,
                           m_out & m_ctrl[2]);
      end
      step();
    end
    rst = 1'b0; sys_write = 1'b0; sys_read = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    sys_w_addr = '0; sys_w_line = '0; sys_write = 1'b0;
    sys_r_addr = '0; sys_read = 1'b0;
    test_reset();
    test_count_reload();
    test_prescaler();
    test_compare_pin();
    test_oneshot();
    test_collisions();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
